// File: rtl/uart_fifo_ctrl_if.sv
// uart_fifo_ctrl_if -- MEM-stage bus between the MIPS32 core and the UART controller.
// The core side drives op/address/store data; the UART side answers with load
// data and a pipeline stall request, both combinational.
interface uart_fifo_ctrl_if;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        pause_req;

    modport master (
        output mem_op,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  pause_req
    );

    modport slave (
        input  mem_op,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output pause_req
    );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl -- memory-mapped UART for the MIPS32 MEM stage.
// TX and RX FIFOs decouple the core from the serial line: byte stores and loads
// only stall when the relevant FIFO is full or empty, and a status register lets
// software poll instead. The 8N1 serialisers live in this file.
// Optional feature macro: UART_IRQ_EN adds a registered irq output
// (rx_avail | overflow) that is also visible as status bit 3.
// OP_LB / OP_SB must carry the `MEM_LB / `MEM_SB codes of the core.
module uart_fifo_ctrl #(
    parameter int          CLK_FREQ  = 50000000,
    parameter int          BAUD      = 9600,
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16,
    parameter logic [31:0] DATA_ADDR = 32'hBFD003F8,
    parameter logic [31:0] STAT_ADDR = 32'hBFD003FC,
    parameter logic [3:0]  OP_LB     = 4'h1,
    parameter logic [3:0]  OP_SB     = 4'h5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rxd,
    output logic                txd,
    uart_fifo_ctrl_if.slave     bus
`ifdef UART_IRQ_EN
    ,
    output logic                irq
`endif
);
    localparam int             DIV     = CLK_FREQ / BAUD;
    localparam int             CW      = $clog2(DIV + 1);
    localparam logic [CW-1:0]  DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0]  HALF_M1 = CW'(DIV / 2 - 1);
    localparam int             TAW     = $clog2(TX_DEPTH);
    localparam int             RAW     = $clog2(RX_DEPTH);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} busState_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_BUSY} drainState_t;

    busState_t   r_busState, w_busNext;
    drainState_t r_drainState;

    logic [7:0]  r_txMem [TX_DEPTH];
    logic [TAW:0] r_txWr, r_txRd, w_txCount;
    logic [7:0]  r_rxMem [RX_DEPTH];
    logic [RAW:0] r_rxWr, r_rxRd, w_rxCount;
    logic        w_txEmpty, w_txFull, w_rxEmpty, w_rxFull;
    logic [7:0]  w_txHead, w_rxHead;
    logic        w_txPush, w_txPop, w_rxPush, w_rxAccept, w_rxPop;

    logic        w_lbData, w_sbData, w_lbStat, w_statRead;
    logic [31:0] w_rdata, w_status;
    logic        w_pause, w_irqBit;
    logic        r_overflow, r_rxClear;

    logic        r_txStart, r_sawBusy, r_txBusy;
    logic [7:0]  r_txData;
    logic [9:0]  r_txShift;
    logic [CW-1:0] r_txDiv, r_rxDiv;
    logic [3:0]  r_txBit, r_rxBit;

    logic [1:0]  r_rxSync;
    logic        r_rxActive, r_rxReady;
    logic [7:0]  r_rxShift, r_rxData;

    logic        w_unusedWdata;

    assign w_unusedWdata = ^bus.mem_wdata[31:8];

    assign w_txCount = r_txWr - r_txRd;
    assign w_txEmpty = (w_txCount == '0);
    assign w_txFull  = (w_txCount == (TAW+1)'(TX_DEPTH));
    assign w_txHead  = r_txMem[r_txRd[TAW-1:0]];
    assign w_rxCount = r_rxWr - r_rxRd;
    assign w_rxEmpty = (w_rxCount == '0);
    assign w_rxFull  = (w_rxCount == (RAW+1)'(RX_DEPTH));
    assign w_rxHead  = r_rxMem[r_rxRd[RAW-1:0]];

    assign w_lbData = (bus.mem_op == OP_LB) && (bus.mem_addr == DATA_ADDR);
    assign w_sbData = (bus.mem_op == OP_SB) && (bus.mem_addr == DATA_ADDR);
    assign w_lbStat = (bus.mem_op == OP_LB) && (bus.mem_addr == STAT_ADDR);

    // A received byte is offered once; the clear pulse masks the cycle before it lands.
    assign w_rxPush   = r_rxReady & ~r_rxClear;
    assign w_rxAccept = w_rxPush & (~w_rxFull | w_rxPop);
    assign w_txPop    = (r_drainState == T_IDLE) && !w_txEmpty && !r_txBusy;

    assign w_status = {16'b0, 8'(w_rxCount), 4'b0, w_irqBit, r_overflow, ~w_rxEmpty, ~w_txFull};

    assign bus.mem_rdata = w_rdata;
    assign bus.pause_req = w_pause;
    assign txd = r_txBusy ? r_txShift[0] : 1'b1;

    // Bus decode: load data, stall request and FIFO push/pop for the current MEM op.
    always_comb begin
        w_rdata    = '0;
        w_pause    = 1'b0;
        w_rxPop    = 1'b0;
        w_txPush   = 1'b0;
        w_statRead = 1'b0;
        w_busNext  = r_busState;
        if (!rst) begin
            if (w_lbData) begin
                if (w_rxEmpty) begin
                    w_pause   = 1'b1;
                    w_busNext = RD_WAIT;
                end else begin
                    w_rdata   = {24'b0, w_rxHead};
                    w_rxPop   = 1'b1;
                    w_busNext = IDLE;
                end
            end else if (w_sbData) begin
                if (w_txFull) begin
                    w_pause   = 1'b1;
                    w_busNext = WR_WAIT;
                end else begin
                    w_txPush  = 1'b1;
                    w_busNext = IDLE;
                end
            end else if (w_lbStat) begin
                w_rdata    = w_status;
                w_statRead = 1'b1;
            end
        end
    end

    // Bus FSM state register; tracks whether the core is parked on a full/empty FIFO.
    always_ff @(posedge clk) begin
        if (rst) r_busState <= IDLE;
        else     r_busState <= w_busNext;
    end

    // FIFO storage arrays need no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_txPush)   r_txMem[r_txWr[TAW-1:0]] <= bus.mem_wdata[7:0];
        if (w_rxAccept) r_rxMem[r_rxWr[RAW-1:0]] <= r_rxData;
    end

    // FIFO pointers with an extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txWr <= '0;
            r_txRd <= '0;
            r_rxWr <= '0;
            r_rxRd <= '0;
        end else begin
            if (w_txPush)   r_txWr <= r_txWr + 1'b1;
            if (w_txPop)    r_txRd <= r_txRd + 1'b1;
            if (w_rxAccept) r_rxWr <= r_rxWr + 1'b1;
            if (w_rxPop)    r_rxRd <= r_rxRd + 1'b1;
        end
    end

    // Sticky overflow (a new drop wins over a same-cycle status read) and receiver clear pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_rxClear  <= 1'b0;
        end else begin
            r_rxClear <= w_rxPush;
            if (w_rxPush && !w_rxAccept) r_overflow <= 1'b1;
            else if (w_statRead)         r_overflow <= 1'b0;
        end
    end

`ifdef UART_IRQ_EN
    logic r_irq;

    // Interrupt follows "data waiting or data lost", one cycle behind.
    always_ff @(posedge clk) begin
        if (rst) r_irq <= 1'b0;
        else     r_irq <= ~w_rxEmpty | r_overflow;
    end

    assign irq      = r_irq;
    assign w_irqBit = r_irq;
`else
    assign w_irqBit = 1'b0;
`endif

    // TX drain FSM: feed one FIFO byte to the transmitter, then wait out its frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drainState <= T_IDLE;
            r_txStart    <= 1'b0;
            r_txData     <= '0;
            r_sawBusy    <= 1'b0;
        end else begin
            r_txStart <= 1'b0;
            case (r_drainState)
                T_IDLE: if (w_txPop) begin
                    r_txData     <= w_txHead;
                    r_txStart    <= 1'b1;
                    r_sawBusy    <= 1'b0;
                    r_drainState <= T_START;
                end
                T_START: r_drainState <= T_BUSY;
                T_BUSY: begin
                    if (r_txBusy)       r_sawBusy    <= 1'b1;
                    else if (r_sawBusy) r_drainState <= T_IDLE;
                end
                default: r_drainState <= T_IDLE;
            endcase
        end
    end

    // 8N1 transmitter: start bit, eight data bits LSB first, stop bit, DIV clocks each.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txBusy  <= 1'b0;
            r_txShift <= '1;
            r_txDiv   <= '0;
            r_txBit   <= '0;
        end else if (!r_txBusy) begin
            if (r_txStart) begin
                r_txBusy  <= 1'b1;
                r_txShift <= {1'b1, r_txData, 1'b0};
                r_txDiv   <= DIV_M1;
                r_txBit   <= '0;
            end
        end else if (r_txDiv != '0) begin
            r_txDiv <= r_txDiv - 1'b1;
        end else begin
            r_txDiv <= DIV_M1;
            if (r_txBit == 4'd9) begin
                r_txBusy <= 1'b0;
            end else begin
                r_txShift <= {1'b1, r_txShift[9:1]};
                r_txBit   <= r_txBit + 1'b1;
            end
        end
    end

    // 8N1 receiver: synchronise rxd, sample mid-bit, hold the byte until cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxSync   <= 2'b11;
            r_rxActive <= 1'b0;
            r_rxDiv    <= '0;
            r_rxBit    <= '0;
            r_rxShift  <= '0;
            r_rxData   <= '0;
            r_rxReady  <= 1'b0;
        end else begin
            r_rxSync <= {r_rxSync[0], rxd};
            if (r_rxClear) r_rxReady <= 1'b0;
            if (!r_rxActive) begin
                if (!r_rxSync[1]) begin
                    r_rxActive <= 1'b1;
                    r_rxDiv    <= HALF_M1;
                    r_rxBit    <= '0;
                end
            end else if (r_rxDiv != '0) begin
                r_rxDiv <= r_rxDiv - 1'b1;
            end else begin
                r_rxDiv <= DIV_M1;
                r_rxBit <= r_rxBit + 1'b1;
                if (r_rxBit == 4'd0) begin
                    if (r_rxSync[1]) r_rxActive <= 1'b0;
                end else if (r_rxBit == 4'd9) begin
                    r_rxActive <= 1'b0;
                    r_rxData   <= r_rxShift;
                    r_rxReady  <= 1'b1;
                end else begin
                    r_rxShift <= {r_rxSync[1], r_rxShift[7:1]};
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl -- self-checking bench for uart_fifo_ctrl.
// A short bit period (16 clocks) and 4-entry FIFOs keep frames cheap to simulate.
// A queue model of the RX FIFO and overflow flag predicts every load and status
// read; a line monitor decodes txd into bytes for the TX checks.
module tb_uart_fifo_ctrl;
    localparam int          BIT    = 16;
    localparam int          TXDEP  = 4;
    localparam int          RXDEP  = 4;
    localparam logic [31:0] DATA_A = 32'hBFD003F8;
    localparam logic [31:0] STAT_A = 32'hBFD003FC;
    localparam logic [3:0]  OP_LB  = 4'h1;
    localparam logic [3:0]  OP_SB  = 4'h5;
    localparam logic [3:0]  OP_NO  = 4'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    wire  txd;
`ifdef UART_IRQ_EN
    wire  irq;
    localparam logic [31:0] IRQ_ST = 32'h8;
`else
    localparam logic [31:0] IRQ_ST = 32'h0;
`endif

    uart_fifo_ctrl_if bus();

    uart_fifo_ctrl #(
        .CLK_FREQ(160), .BAUD(10), .TX_DEPTH(TXDEP), .RX_DEPTH(RXDEP),
        .DATA_ADDR(DATA_A), .STAT_ADDR(STAT_A), .OP_LB(OP_LB), .OP_SB(OP_SB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .txd(txd),
        .bus(bus)
`ifdef UART_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int   passCount = 0;
    int   checkCount = 0;
    logic [7:0] rxModel[$];
    logic ovfModel = 1'b0;
    logic irqNext = 1'b0;
    logic cmpEn = 1'b0;
    logic [7:0] txSeen[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk);
        #1;
        bus.mem_op    = op;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
    endtask

    task automatic sendRx(input logic [7:0] b);
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = b[i];
            repeat (BIT) @(posedge clk);
        end
        #1 rxd = 1'b1;
        repeat (BIT + 4) @(posedge clk);
    endtask

    // Full frame delivered: the byte is either queued or dropped as overflow.
    task automatic sendRxByte(input logic [7:0] b);
        cmpEn = 1'b0;
        sendRx(b);
        if (rxModel.size() < RXDEP) rxModel.push_back(b);
        else ovfModel = 1'b1;
        repeat (2) @(posedge clk);
        #1 cmpEn = 1'b1;
    endtask

    task automatic waitTxBytes(input int n, input int budget);
        int c;
        c = 0;
        while (txSeen.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        checkOutput("tx_frame_count", txSeen.size(), n);
    endtask

    // Decode 8N1 frames on txd, sampling each bit mid-period.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge txd);
            repeat (BIT / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(posedge clk);
                b = {txd, b[7:1]};
            end
            repeat (BIT) @(posedge clk);
            txSeen.push_back(b);
        end
    end

    // Per-cycle comparison of load data, stall and irq against the queue model.
    always @(negedge clk) begin
        logic expIrq;
        expIrq = irqNext;
        irqNext = rst ? 1'b0 : ((rxModel.size() != 0) || ovfModel);
        if (cmpEn && !rst) begin
            if (bus.mem_op == OP_LB && bus.mem_addr == DATA_A) begin
                if (rxModel.size() != 0) begin
                    checkOutput("model_rx_data", bus.mem_rdata, {24'b0, rxModel[0]});
                    checkOutput("model_rx_pause", {31'b0, bus.pause_req}, 32'h0);
                    void'(rxModel.pop_front());
                end else begin
                    checkOutput("model_rx_empty_data", bus.mem_rdata, 32'h0);
                    checkOutput("model_rx_empty_pause", {31'b0, bus.pause_req}, 32'h1);
                end
            end else if (bus.mem_op == OP_LB && bus.mem_addr == STAT_A) begin
`ifdef UART_IRQ_EN
                checkOutput("model_status", bus.mem_rdata,
                            {16'b0, 8'(rxModel.size()), 4'b0, expIrq, ovfModel, rxModel.size() != 0, 1'b1});
`else
                checkOutput("model_status", bus.mem_rdata,
                            {16'b0, 8'(rxModel.size()), 4'b0, 1'b0, ovfModel, rxModel.size() != 0, 1'b1});
`endif
                checkOutput("model_status_pause", {31'b0, bus.pause_req}, 32'h0);
                ovfModel = 1'b0;
            end else begin
                checkOutput("model_idle_data", bus.mem_rdata, 32'h0);
                if (bus.mem_op != OP_SB || bus.mem_addr != DATA_A)
                    checkOutput("model_idle_pause", {31'b0, bus.pause_req}, 32'h0);
            end
`ifdef UART_IRQ_EN
            checkOutput("model_irq", {31'b0, irq}, {31'b0, expIrq});
`endif
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int stall;
        int w;
        int base;
        bus.mem_op = OP_LB;
        bus.mem_addr = DATA_A;
        bus.mem_wdata = '0;

        // Reset: LB of empty RX must not stall while rst is high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_pause", {31'b0, bus.pause_req}, 32'h0);
        checkOutput("reset_rdata", bus.mem_rdata, 32'h0);
        checkOutput("reset_txd", {31'b0, txd}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.mem_op = OP_NO;
        cmpEn = 1'b1;

        applyStimulus(OP_LB, STAT_A, 0);
        @(negedge clk);
        checkOutput("status_after_reset", bus.mem_rdata, 32'h00000001);

        // Two back-to-back stores, no stall, both framed on txd.
        applyStimulus(OP_SB, DATA_A, 32'h41);
        @(negedge clk);
        checkOutput("sb41_pause", {31'b0, bus.pause_req}, 32'h0);
        applyStimulus(OP_SB, DATA_A, 32'hFFFFFF42);
        @(negedge clk);
        checkOutput("sb42_pause", {31'b0, bus.pause_req}, 32'h0);
        applyStimulus(OP_NO, 0, 0);
        waitTxBytes(2, 3 * 10 * BIT);
        if (txSeen.size() >= 2) begin
            checkOutput("txd_byte0", {24'b0, txSeen.pop_front()}, 32'h41);
            checkOutput("txd_byte1", {24'b0, txSeen.pop_front()}, 32'h42);
        end
        repeat (2 * BIT) @(posedge clk);

        // TX full: first byte moves straight into the serialiser, so the FIFO
        // fills on store TXDEP+1 and store TXDEP+2 stalls for about one frame.
        for (int k = 0; k < TXDEP + 1; k++) begin
            applyStimulus(OP_SB, DATA_A, 32'h10 + k);
            @(negedge clk);
            checkOutput("tx_fill_pause", {31'b0, bus.pause_req}, 32'h0);
        end
        applyStimulus(OP_SB, DATA_A, 32'h10 + TXDEP + 1);
        @(negedge clk);
        checkOutput("tx_full_stall", {31'b0, bus.pause_req}, 32'h1);
        stall = 0;
        while (bus.pause_req && stall < 400) begin
            stall++;
            @(negedge clk);
        end
        checkOutput("tx_stall_len", {31'b0, (stall >= 8 * BIT && stall <= 11 * BIT)}, 32'h1);
        applyStimulus(OP_NO, 0, 0);
        waitTxBytes(TXDEP + 2, (TXDEP + 3) * 10 * BIT);
        for (int k = 0; k < TXDEP + 2; k++)
            if (txSeen.size() != 0)
                checkOutput("tx_order", {24'b0, txSeen.pop_front()}, 32'h10 + k);
        repeat (2 * BIT) @(posedge clk);

        // Load with RX empty stalls until 0x5A lands, then returns it.
        cmpEn = 1'b0;
        applyStimulus(OP_LB, DATA_A, 0);
        @(negedge clk);
        checkOutput("rdwait_pause", {31'b0, bus.pause_req}, 32'h1);
        checkOutput("rdwait_rdata", bus.mem_rdata, 32'h0);
        fork
            sendRx(8'h5A);
            begin
                w = 0;
                while (bus.pause_req && w < 20 * BIT) begin
                    @(negedge clk);
                    w++;
                end
                checkOutput("rdwait_release", {31'b0, bus.pause_req}, 32'h0);
                checkOutput("rdwait_data", bus.mem_rdata, 32'h0000005A);
                applyStimulus(OP_NO, 0, 0);
            end
        join
        #1 cmpEn = 1'b1;
        applyStimulus(OP_LB, STAT_A, 0);
        @(negedge clk);
        checkOutput("status_after_rdwait", bus.mem_rdata, 32'h00000001);
        applyStimulus(OP_NO, 0, 0);

        // RX overflow: RXDEP+1 bytes, only the first RXDEP kept.
        for (int k = 0; k < RXDEP + 1; k++) sendRxByte(8'hA0 + 8'(k));
        applyStimulus(OP_LB, STAT_A, 0);
        @(negedge clk);
        checkOutput("status_overflow", bus.mem_rdata, 32'h00000407 | IRQ_ST);
        applyStimulus(OP_NO, 0, 0);
        applyStimulus(OP_LB, STAT_A, 0);
        @(negedge clk);
        checkOutput("status_ovf_cleared", bus.mem_rdata, 32'h00000403 | IRQ_ST);
        for (int k = 0; k < RXDEP; k++) begin
            applyStimulus(OP_LB, DATA_A, 0);
            @(negedge clk);
            checkOutput("rx_kept_byte", bus.mem_rdata, 32'hA0 + k);
        end
        applyStimulus(OP_LB, STAT_A, 0);
        applyStimulus(OP_NO, 0, 0);

        // Reset while the drain FSM is mid-frame with bytes still queued.
        for (int k = 0; k < TXDEP + 1; k++) applyStimulus(OP_SB, DATA_A, 32'h60 + k);
        applyStimulus(OP_NO, 0, 0);
        repeat (3 * BIT) @(posedge clk);
        cmpEn = 1'b0;
        applyStimulus(OP_LB, DATA_A, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_pause", {31'b0, bus.pause_req}, 32'h0);
        checkOutput("midreset_rdata", bus.mem_rdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.mem_op = OP_NO;
        rxModel.delete();
        ovfModel = 1'b0;
        repeat (10 * BIT) @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_txd_idle", {31'b0, txd}, 32'h1);
        base = txSeen.size();
        repeat (30 * BIT) @(posedge clk);
        checkOutput("midreset_no_more_frames", txSeen.size(), base);
        #1 cmpEn = 1'b1;
        applyStimulus(OP_LB, STAT_A, 0);
        @(negedge clk);
        checkOutput("status_after_midreset", bus.mem_rdata, 32'h00000001);
`ifdef UART_IRQ_EN
        checkOutput("irq_after_midreset", {31'b0, irq}, 32'h0);
`endif
        applyStimulus(OP_NO, 0, 0);
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
